// File: rtl/interface_hcsr04_multi.sv
// Multi-channel HC-SR04 ultrasonic interface.
// One medir request scans every channel in turn: trigger pulse, echo width
// measurement, rounded and saturated conversion to centimetres, then an
// acoustic guard gap before the next channel fires.
module interface_hcsr04_multi #(
  parameter int N_CH        = 2,
  parameter int W           = 12,
  parameter int TRIG_CYC    = 500,
  parameter int CYC_PER_CM  = 2941,
  parameter int TIMEOUT_CYC = 1500000,
  parameter int GAP_CYC     = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trigger,
  output logic [N_CH*W-1:0] medida,
  output logic [N_CH-1:0]   valido,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int MAX_A = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int MAX_C = (MAX_A > TRIG_CYC) ? MAX_A : TRIG_CYC;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int SW    = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HALF  = CYC_PER_CM / 2;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_TRIG  = 4'd1,
    S_WAIT  = 4'd2,
    S_MEAS  = 4'd3,
    S_STORE = 4'd4,
    S_GAP   = 4'd5,
    S_DONE  = 4'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cntNext;
  logic [SW-1:0]     r_sub;
  logic [SW-1:0]     w_subNext;
  logic [SW-1:0]     w_subStep;
  logic [W-1:0]      r_cm;
  logic [W-1:0]      w_cmNext;
  logic [W-1:0]      w_cmStep;
  logic [CHW-1:0]    r_ch;
  logic [CHW-1:0]    w_chNext;
  logic              r_tmo;
  logic              w_tmoNext;
  logic [N_CH-1:0]   r_echoMeta;
  logic [N_CH-1:0]   r_echoSync;
  logic              w_echo;
  logic [N_CH-1:0]   r_trigger;
  logic [N_CH*W-1:0] r_medida;
  logic [N_CH-1:0]   r_valido;
  logic              r_ocupado;
  logic              r_pronto;

  assign w_echo    = r_echoSync[r_ch];
  assign trigger   = r_trigger;
  assign medida    = r_medida;
  assign valido    = r_valido;
  assign ocupado   = r_ocupado;
  assign pronto    = r_pronto;
  assign db_estado = r_state;

  // Two-flop synchroniser for every asynchronous echo pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_echoMeta <= '0;
      r_echoSync <= '0;
    end else begin
      r_echoMeta <= echo;
      r_echoSync <= r_echoMeta;
    end
  end

  // One echo-high cycle of the divider-free converter: the sub-counter wraps every CYC_PER_CM cycles and bumps the saturating cm count.
  always_comb begin
    w_subStep = r_sub + SW'(1);
    w_cmStep  = r_cm;
    if (r_sub == SW'(CYC_PER_CM - 1)) begin
      w_subStep = '0;
      if (r_cm != {W{1'b1}}) w_cmStep = r_cm + W'(1);
    end
  end

  // Next-state and datapath control for the channel scan.
  always_comb begin
    w_next    = r_state;
    w_cntNext = r_cnt;
    w_subNext = r_sub;
    w_cmNext  = r_cm;
    w_chNext  = r_ch;
    w_tmoNext = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (medir) begin
          w_next    = S_TRIG;
          w_chNext  = '0;
          w_cntNext = '0;
        end
      end
      S_TRIG: begin
        // Preloading half a centimetre of cycles turns the truncating count into round-to-nearest.
        w_subNext = SW'(HALF);
        w_cmNext  = '0;
        w_tmoNext = 1'b0;
        if (r_cnt == CW'(TRIG_CYC - 1)) begin
          w_next    = S_WAIT;
          w_cntNext = '0;
        end else begin
          w_cntNext = r_cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (w_echo) begin
          // The cycle that detects the rising echo is already an echo-high cycle, so it is counted.
          w_next    = S_MEAS;
          w_cntNext = CW'(1);
          w_subNext = w_subStep;
          w_cmNext  = w_cmStep;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_next    = S_STORE;
          w_tmoNext = 1'b1;
          w_cntNext = '0;
        end else begin
          w_cntNext = r_cnt + CW'(1);
        end
      end
      S_MEAS: begin
        if (!w_echo) begin
          w_next    = S_STORE;
          w_cntNext = '0;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_next    = S_STORE;
          w_tmoNext = 1'b1;
          w_cntNext = '0;
        end else begin
          w_cntNext = r_cnt + CW'(1);
          w_subNext = w_subStep;
          w_cmNext  = w_cmStep;
        end
      end
      S_STORE: begin
        w_next    = S_GAP;
        w_cntNext = '0;
      end
      S_GAP: begin
        if (r_cnt == CW'(GAP_CYC - 1)) begin
          w_cntNext = '0;
          if (r_ch == CHW'(N_CH - 1)) begin
            w_next = S_DONE;
          end else begin
            w_next   = S_TRIG;
            w_chNext = r_ch + CHW'(1);
          end
        end else begin
          w_cntNext = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State and working registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sub   <= '0;
      r_cm    <= '0;
      r_ch    <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cntNext;
      r_sub   <= w_subNext;
      r_cm    <= w_cmNext;
      r_ch    <= w_chNext;
      r_tmo   <= w_tmoNext;
    end
  end

  // Registered outputs, decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_trigger <= '0;
      r_medida  <= '0;
      r_valido  <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_trigger <= (w_next == S_TRIG) ? (N_CH'(1) << w_chNext) : '0;
      r_ocupado <= (w_next != S_IDLE);
      r_pronto  <= (w_next == S_DONE);
      for (int i = 0; i < N_CH; i++) begin
        if (r_state == S_STORE && r_ch == CHW'(i)) begin
          r_medida[i*W +: W] <= r_tmo ? {W{1'b1}} : r_cm;
          r_valido[i]        <= ~r_tmo;
        end
      end
    end
  end

endmodule
